// File: rtl/fb_write_sched.sv
// Framebuffer write scheduler: merges a cursor (draw) and a replay (load) pixel stream
// with round-robin arbitration, and preempts both with a full-screen raster clear sweep.
module fb_write_sched #(
  parameter int   H_RES       = 640,
  parameter int   V_RES       = 480,
  parameter logic CLEAR_COLOR = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear_req,
  input  logic        draw_valid,
  input  logic [10:0] draw_x,
  input  logic [10:0] draw_y,
  output logic        draw_ready,
  input  logic        load_valid,
  input  logic [10:0] load_x,
  input  logic [10:0] load_y,
  input  logic        load_color,
  output logic        load_ready,
  output logic [10:0] fb_x,
  output logic [10:0] fb_y,
  output logic        fb_color,
  output logic        fb_write,
  output logic        busy_clear,
  output logic        clear_done
);

  localparam logic       IDLE       = 1'b0;
  localparam logic       CLEAR      = 1'b1;
  localparam logic       GRANT_DRAW = 1'b0;
  localparam logic       GRANT_LOAD = 1'b1;
  localparam logic [10:0] H_LIM     = 11'(H_RES);
  localparam logic [10:0] V_LIM     = 11'(V_RES);
  localparam logic [10:0] H_LAST    = 11'(H_RES - 1);
  localparam logic [10:0] V_LAST    = 11'(V_RES - 1);

  logic        state_q, state_d;
  logic [10:0] cx_q, cx_d;
  logic [10:0] cy_q, cy_d;
  logic        last_grant_q, last_grant_d;
  logic [10:0] fb_x_q, fb_x_d;
  logic [10:0] fb_y_q, fb_y_d;
  logic        fb_color_q, fb_color_d;
  logic        fb_write_q, fb_write_d;
  logic        clear_done_q, clear_done_d;
  logic        draw_grant, load_grant;
  logic        draw_in_range, load_in_range;

  assign draw_in_range = (draw_x < H_LIM) && (draw_y < V_LIM);
  assign load_in_range = (load_x < H_LIM) && (load_y < V_LIM);

  // Next-state: arbitration, clear sweep and the registered write port
  always_comb begin
    state_d      = state_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    last_grant_d = last_grant_q;
    fb_x_d       = fb_x_q;
    fb_y_d       = fb_y_q;
    fb_color_d   = fb_color_q;
    fb_write_d   = 1'b0;
    clear_done_d = 1'b0;
    draw_grant   = 1'b0;
    load_grant   = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          cx_d    = 11'd0;
          cy_d    = 11'd0;
        end else if (!reset_n) begin
          draw_grant = 1'b0;
          load_grant = 1'b0;
        end else if (draw_valid && load_valid) begin
          // Tie goes to whoever did not win the previous accepted transfer
          if (last_grant_q == GRANT_DRAW) begin
            load_grant = 1'b1;
          end else begin
            draw_grant = 1'b1;
          end
        end else begin
          draw_grant = draw_valid;
          load_grant = load_valid;
        end
      end
      CLEAR: begin
        fb_x_d     = cx_q;
        fb_y_d     = cy_q;
        fb_color_d = CLEAR_COLOR;
        fb_write_d = 1'b1;
        if (cx_q == H_LAST) begin
          cx_d = 11'd0;
          if (cy_q == V_LAST) begin
            state_d      = IDLE;
            cy_d         = 11'd0;
            clear_done_d = 1'b1;
          end else begin
            cy_d = cy_q + 11'd1;
          end
        end else begin
          cx_d = cx_q + 11'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Out-of-range pixels are still accepted, just never written
    if (draw_grant) begin
      last_grant_d = GRANT_DRAW;
      if (draw_in_range) begin
        fb_x_d     = draw_x;
        fb_y_d     = draw_y;
        fb_color_d = 1'b1;
        fb_write_d = 1'b1;
      end else begin
        fb_write_d = 1'b0;
      end
    end else if (load_grant) begin
      last_grant_d = GRANT_LOAD;
      if (load_in_range) begin
        fb_x_d     = load_x;
        fb_y_d     = load_y;
        fb_color_d = load_color;
        fb_write_d = 1'b1;
      end else begin
        fb_write_d = 1'b0;
      end
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cx_q         <= 11'd0;
      cy_q         <= 11'd0;
      last_grant_q <= GRANT_DRAW;
      fb_x_q       <= 11'd0;
      fb_y_q       <= 11'd0;
      fb_color_q   <= 1'b0;
      fb_write_q   <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      last_grant_q <= last_grant_d;
      fb_x_q       <= fb_x_d;
      fb_y_q       <= fb_y_d;
      fb_color_q   <= fb_color_d;
      fb_write_q   <= fb_write_d;
      clear_done_q <= clear_done_d;
    end
  end

  assign draw_ready = draw_grant;
  assign load_ready = load_grant;
  assign fb_x       = fb_x_q;
  assign fb_y       = fb_y_q;
  assign fb_color   = fb_color_q;
  assign fb_write   = fb_write_q;
  assign busy_clear = (state_q == CLEAR);
  assign clear_done = clear_done_q;

endmodule

// File: tb/tb_fb_write_sched.sv
// Directed bench for fb_write_sched on a reduced 32x24 screen: vector table for
// arbitration and range handling, hand sequences for clear, restart and reset-abort.
module tb_fb_write_sched;

  localparam int   H   = 32;
  localparam int   V   = 24;
  localparam int   N   = H * V;
  localparam logic CLR = 1'b0;

  logic        clk = 1'b0;
  logic        reset_n, clear_req;
  logic        draw_valid, draw_ready, load_valid, load_ready, load_color;
  logic [10:0] draw_x, draw_y, load_x, load_y, fb_x, fb_y;
  logic        fb_color, fb_write, busy_clear, clear_done;

  int total = 0;
  int bad   = 0;
  int writes, dones, bad_px, rdy_seen, busy_seen;
  logic [10:0] done_x, done_y;

  typedef struct {
    logic        dv;
    logic [10:0] dx, dy;
    logic        lv;
    logic [10:0] lx, ly;
    logic        lc;
    logic        exp_dr, exp_lr, exp_fw;
    logic [10:0] exp_fx, exp_fy;
    logic        exp_fc;
  } vec_t;

  vec_t vecs[12];

  fb_write_sched #(.H_RES(H), .V_RES(V), .CLEAR_COLOR(CLR)) dut (
    .clk(clk), .reset_n(reset_n), .clear_req(clear_req),
    .draw_valid(draw_valid), .draw_x(draw_x), .draw_y(draw_y), .draw_ready(draw_ready),
    .load_valid(load_valid), .load_x(load_x), .load_y(load_y), .load_color(load_color),
    .load_ready(load_ready),
    .fb_x(fb_x), .fb_y(fb_y), .fb_color(fb_color), .fb_write(fb_write),
    .busy_clear(busy_clear), .clear_done(clear_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Runs a clear from IDLE; restart_at/abort_at pick the sweep cycle that pulses clear_req / reset_n
  task automatic run_clear(input int cycles, input int restart_at, input int abort_at);
    writes = 0; dones = 0; bad_px = 0; rdy_seen = 0; busy_seen = 0;
    done_x = 11'd0; done_y = 11'd0;
    clear_req = 1'b1;
    #1;
    check("clr_req_draw_ready", draw_ready, 0);
    check("clr_req_load_ready", load_ready, 0);
    @(posedge clk); #1;
    for (int i = 0; i < cycles; i++) begin
      clear_req = (i == restart_at);
      reset_n   = (i != abort_at);
      #1;
      if (draw_ready || load_ready) rdy_seen++;
      if (busy_clear) busy_seen++;
      @(posedge clk); #1;
      if (fb_write) begin
        if (fb_x !== 11'(writes % H) || fb_y !== 11'(writes / H) || fb_color !== CLR) bad_px++;
        writes++;
      end
      if (clear_done) begin
        dones++;
        done_x = fb_x;
        done_y = fb_y;
        if (!fb_write) bad_px++;
      end
    end
    clear_req = 1'b0;
    reset_n   = 1'b1;
  endtask

  initial begin
    // dv dx dy lv lx ly lc | dr lr fw fx fy fc
    vecs[0]  = '{1'b1, 11'd10, 11'd20, 1'b0, 11'd0,  11'd0,  1'b0, 1'b1, 1'b0, 1'b1, 11'd10, 11'd20, 1'b1};
    vecs[1]  = '{1'b0, 11'd0,  11'd0,  1'b0, 11'd0,  11'd0,  1'b0, 1'b0, 1'b0, 1'b0, 11'd10, 11'd20, 1'b1};
    vecs[2]  = '{1'b1, 11'd7,  11'd7,  1'b1, 11'd5,  11'd5,  1'b0, 1'b0, 1'b1, 1'b1, 11'd5,  11'd5,  1'b0};
    vecs[3]  = '{1'b1, 11'd7,  11'd7,  1'b1, 11'd5,  11'd5,  1'b0, 1'b1, 1'b0, 1'b1, 11'd7,  11'd7,  1'b1};
    vecs[4]  = '{1'b1, 11'd7,  11'd7,  1'b1, 11'd5,  11'd5,  1'b0, 1'b0, 1'b1, 1'b1, 11'd5,  11'd5,  1'b0};
    vecs[5]  = '{1'b1, 11'd7,  11'd7,  1'b1, 11'd5,  11'd5,  1'b0, 1'b1, 1'b0, 1'b1, 11'd7,  11'd7,  1'b1};
    vecs[6]  = '{1'b0, 11'd0,  11'd0,  1'b1, 11'd31, 11'd23, 1'b0, 1'b0, 1'b1, 1'b1, 11'd31, 11'd23, 1'b0};
    vecs[7]  = '{1'b0, 11'd0,  11'd0,  1'b1, 11'd32, 11'd3,  1'b1, 1'b0, 1'b1, 1'b0, 11'd31, 11'd23, 1'b0};
    vecs[8]  = '{1'b0, 11'd0,  11'd0,  1'b1, 11'd3,  11'd24, 1'b1, 1'b0, 1'b1, 1'b0, 11'd31, 11'd23, 1'b0};
    vecs[9]  = '{1'b1, 11'd0,  11'd0,  1'b0, 11'd0,  11'd0,  1'b0, 1'b1, 1'b0, 1'b1, 11'd0,  11'd0,  1'b1};
    vecs[10] = '{1'b1, 11'd40, 11'd1,  1'b1, 11'd2,  11'd2,  1'b1, 1'b0, 1'b1, 1'b1, 11'd2,  11'd2,  1'b1};
    vecs[11] = '{1'b1, 11'd40, 11'd1,  1'b1, 11'd2,  11'd2,  1'b1, 1'b1, 1'b0, 1'b0, 11'd2,  11'd2,  1'b1};

    reset_n = 1'b0; clear_req = 1'b0;
    draw_valid = 1'b0; draw_x = 11'd0; draw_y = 11'd0;
    load_valid = 1'b0; load_x = 11'd0; load_y = 11'd0; load_color = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    draw_valid = 1'b1;
    #1;
    check("rst_draw_ready", draw_ready, 0);
    check("rst_fb_write", fb_write, 0);
    check("rst_fb_x", fb_x, 0);
    check("rst_fb_y", fb_y, 0);
    check("rst_fb_color", fb_color, 0);
    check("rst_busy", busy_clear, 0);
    check("rst_done", clear_done, 0);
    draw_valid = 1'b0;
    reset_n    = 1'b1;

    for (int k = 0; k < 12; k++) begin
      draw_valid = vecs[k].dv; draw_x = vecs[k].dx; draw_y = vecs[k].dy;
      load_valid = vecs[k].lv; load_x = vecs[k].lx; load_y = vecs[k].ly; load_color = vecs[k].lc;
      #1;
      check($sformatf("v%0d_draw_ready", k), draw_ready, vecs[k].exp_dr);
      check($sformatf("v%0d_load_ready", k), load_ready, vecs[k].exp_lr);
      @(posedge clk); #1;
      check($sformatf("v%0d_fb_write", k), fb_write, vecs[k].exp_fw);
      check($sformatf("v%0d_fb_x", k), fb_x, vecs[k].exp_fx);
      check($sformatf("v%0d_fb_y", k), fb_y, vecs[k].exp_fy);
      check($sformatf("v%0d_fb_color", k), fb_color, vecs[k].exp_fc);
      check($sformatf("v%0d_clear_done", k), clear_done, 0);
    end
    draw_valid = 1'b0; load_valid = 1'b0;

    // Full clear with a cursor pixel held the whole time
    draw_valid = 1'b1; draw_x = 11'd4; draw_y = 11'd4;
    run_clear(N, -1, -1);
    check("clrA_writes", writes, N);
    check("clrA_dones", dones, 1);
    check("clrA_bad_px", bad_px, 0);
    check("clrA_ready_seen", rdy_seen, 0);
    check("clrA_busy_cycles", busy_seen, N);
    check("clrA_last_x", done_x, H - 1);
    check("clrA_last_y", done_y, V - 1);
    #1;
    check("clrA_after_draw_ready", draw_ready, 1);
    check("clrA_after_busy", busy_clear, 0);
    @(posedge clk); #1;
    check("clrA_after_fb_write", fb_write, 1);
    check("clrA_after_fb_x", fb_x, 4);
    check("clrA_after_fb_y", fb_y, 4);
    check("clrA_after_fb_color", fb_color, 1);
    check("clrA_after_done", clear_done, 0);
    draw_valid = 1'b0;

    // clear_req re-asserted mid-sweep must not restart it
    run_clear(N + 4, 50, -1);
    check("clrB_writes", writes, N);
    check("clrB_dones", dones, 1);
    check("clrB_bad_px", bad_px, 0);
    check("clrB_busy_cycles", busy_seen, N);
    check("clrB_last_x", done_x, H - 1);
    check("clrB_last_y", done_y, V - 1);

    // Reset in the middle of a sweep aborts it silently
    run_clear(120, -1, 100);
    check("clrC_writes", writes, 100);
    check("clrC_dones", dones, 0);
    check("clrC_bad_px", bad_px, 0);
    check("clrC_busy", busy_clear, 0);
    check("clrC_fb_x", fb_x, 0);
    check("clrC_fb_y", fb_y, 0);
    draw_valid = 1'b1; draw_x = 11'd1; draw_y = 11'd1;
    #1;
    check("clrC_draw_ready", draw_ready, 1);
    @(posedge clk); #1;
    check("clrC_draw_fb_write", fb_write, 1);
    check("clrC_draw_fb_x", fb_x, 1);
    check("clrC_draw_fb_y", fb_y, 1);
    check("clrC_draw_fb_color", fb_color, 1);
    draw_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fb_write_sched.md
FB_WRITE_SCHED -- requirements
Module: fb_write_sched

Interface
REQ-001 SHALL have parameter H_RES, default 640: horizontal pixel count.
REQ-002 SHALL have parameter V_RES, default 480: vertical pixel count.
REQ-003 SHALL have parameter CLEAR_COLOR, default 1'b0: pixel value written by the clear sweep.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n  input  1  synchronous active-low reset.
REQ-006 SHALL have port clear_req  input  1  request a full-screen clear; sampled each cycle.
REQ-007 SHALL have port draw_valid  input  1  cursor requester has a pixel.
REQ-008 SHALL have port draw_x, draw_y  input  11 each  cursor pixel coordinate; draw color is fixed at 1.
REQ-009 SHALL have port draw_ready  output  1  cursor pixel accepted this cycle when high with draw_valid.
REQ-010 SHALL have port load_valid  input  1  replay requester has a pixel.
REQ-011 SHALL have port load_x, load_y  input  11 each  replay pixel coordinate.
REQ-012 SHALL have port load_color  input  1  replay pixel value.
REQ-013 SHALL have port load_ready  output  1  replay pixel accepted this cycle when high with load_valid.
REQ-014 SHALL have port fb_x, fb_y  output  11 each  framebuffer write coordinate, registered.
REQ-015 SHALL have port fb_color  output  1  framebuffer write value, registered.
REQ-016 SHALL have port fb_write  output  1  framebuffer write strobe, registered, one cycle per pixel.
REQ-017 SHALL have port busy_clear  output  1  high while the clear sweep runs.
REQ-018 SHALL have port clear_done  output  1  one-cycle pulse after the last clear pixel issues.

Function
REQ-019 SHALL implement FSM states IDLE and CLEAR.
REQ-020 IDLE->CLEAR SHALL occur on any cycle with clear_req=1; the sweep counters load (0,0).
REQ-021 In CLEAR, each cycle SHALL issue one write (cx,cy,CLEAR_COLOR), in raster order: cx increments, wraps at H_RES-1 to 0 with cy+1.
REQ-022 CLEAR->IDLE SHALL occur on the cycle (H_RES-1,V_RES-1) issues; clear_done pulses the next cycle, coincident with that pixel's fb_write.
REQ-023 A clear SHALL take exactly H_RES*V_RES cycles; with defaults, 307200.
REQ-024 clear_req during CLEAR SHALL be ignored; the sweep does not restart.
REQ-025 busy_clear SHALL equal (state==CLEAR).
REQ-026 draw_ready and load_ready SHALL be combinational and both 0 in CLEAR, when clear_req=1 in IDLE, and while reset_n=0.
REQ-027 In IDLE, if exactly one requester is valid, that requester's ready SHALL be 1.
REQ-028 If both are valid, grant SHALL be round-robin: the requester not granted last wins; a 1-bit last_grant register updates only on an accepted transfer.
REQ-029 The ready of a requester that is not valid SHALL be 0, so ready never grants an idle requester.
REQ-030 A transfer SHALL occur on valid&ready; its pixel appears on fb_x/fb_y/fb_color with fb_write=1 exactly one cycle later.
REQ-031 A transfer with x>=H_RES or y>=V_RES SHALL be accepted (ready=1) but dropped: fb_write=0 next cycle.
REQ-032 A requester with valid=1 and ready=0 SHALL hold its pixel; the block never drops a held pixel.
REQ-033 With no transfer and no clear pixel, fb_write SHALL be 0; fb_x/fb_y/fb_color hold their last values.
REQ-034 At most one write SHALL issue per cycle; sustained throughput is 1 pixel/cycle.

Reset
REQ-035 On a clock edge with reset_n=0, state SHALL go to IDLE and the sweep counters to (0,0).
REQ-036 The same edge SHALL set fb_x=0, fb_y=0, fb_color=0, fb_write=0, clear_done=0, last_grant=draw, so load wins the first tie.
REQ-037 Reset during CLEAR SHALL abort the sweep with no clear_done; after release the block is IDLE and no further clear pixels issue.

Verification
REQ-038 Reset then draw_valid=1 at (10,20) for 1 cycle -> draw_ready=1 that cycle; next cycle fb_write=1, fb=(10,20), color 1.
REQ-039 draw and load both valid for 4 cycles, load (5,5,0) and draw (7,7,1) -> accept order load, draw, load, draw; fb_write high 4 consecutive cycles.
REQ-040 clear_req pulse with draw_valid held -> draw_ready=0 for 307200 cycles; fb_write high for 307200 cycles; first pixel (0,0), pixel 641 is (0,1), last (639,479); clear_done once; draw then accepted the cycle after the sweep ends.
REQ-041 load_valid with (640,3) then (3,480) -> load_ready=1 both cycles, fb_write=0 the cycle after each.
REQ-042 reset_n=0 at sweep pixel 1000 -> next cycle fb_write=0 and busy_clear=0; clear_done never pulses; a draw at (1,1) then writes normally.
REQ-043 clear_req re-asserted at sweep pixel 50 -> sweep continues to (639,479) with no restart; total 307200 writes.
